// File: rtl/crc16_check.sv
// Serial packet CRC16 checker: skips the 8-bit PID, runs the x^16+x^15+x^2+1 residual check, flags length errors.
// Optional build macro CRC16_CHK_STRIP_EN: on a good packet the trailing 16 CRC bits are zeroed and dropped from pkt_len.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | waiting for rx_start; stray bits and pkt_end ignored
// S_PID   | storing the first 8 bits (PID), CRC register frozen
// S_CHECK | storing bits and shifting them into the CRC register
// S_DONE  | pkt_valid pulse with final data/status, then back to idle
module crc16_check (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          rx_start,
    input  logic          in_bit,
    input  logic          in_valid,
    input  logic          pkt_end,
    output logic [99:0]   pkt_out,
    output logic [31:0]   pkt_len,
    output logic          pkt_valid,
    output logic          crc_ok,
    output logic          crc_err,
    output logic          len_err,
    output logic          busy
);

    typedef enum logic [1:0] {S_IDLE, S_PID, S_CHECK, S_DONE} state_t;

    localparam logic [15:0] CRC_INIT     = 16'hFFFF;
    localparam logic [15:0] CRC_RESIDUAL = 16'h800D;
    localparam logic [31:0] MAX_BITS     = 32'd100;
    localparam logic [31:0] MIN_BITS     = 32'd24;

    state_t        state_q;
    logic [15:0]   crc_q, crc_d;
    logic [31:0]   cnt_q, cnt_d;
    logic          ovf_q, ovf_d;
    logic [99:0]   pkt_out_q, pkt_out_d;
    logic [31:0]   pkt_len_q;
    logic          pkt_valid_q, crc_ok_q, crc_err_q, len_err_q, busy_q;

    logic          accept;
    logic          fb;
    logic          good_d;
    logic [99:0]   final_out;
    logic [31:0]   final_len;

    always_comb begin
        accept    = in_valid && (state_q == S_PID || state_q == S_CHECK);
        fb        = in_bit ^ crc_q[15];
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        crc_d     = crc_q;
        pkt_out_d = pkt_out_q;
        if (accept) begin
            if (cnt_q != 32'hFFFF_FFFF)
                cnt_d = cnt_q + 32'd1;
            if (cnt_q >= MAX_BITS)
                ovf_d = 1'b1;
            else
                pkt_out_d[cnt_q[6:0]] = in_bit;
            if (state_q == S_CHECK)
                crc_d = {crc_q[14] ^ fb, crc_q[13:2], crc_q[1] ^ fb, crc_q[0], fb};
        end
        // status reflects a bit accepted in the same cycle as pkt_end
        good_d    = (cnt_d >= MIN_BITS) && !ovf_d && (crc_d == CRC_RESIDUAL);
        final_out = pkt_out_d;
        final_len = cnt_d;
`ifdef CRC16_CHK_STRIP_EN
        if (good_d) begin
            final_len = cnt_d - 32'd16;
            for (int i = 0; i < 100; i++) begin
                if (32'(i) >= final_len)
                    final_out[i] = 1'b0;
            end
        end
`endif
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            crc_q       <= CRC_INIT;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            pkt_out_q   <= '0;
            pkt_len_q   <= '0;
            pkt_valid_q <= 1'b0;
            crc_ok_q    <= 1'b0;
            crc_err_q   <= 1'b0;
            len_err_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            pkt_valid_q <= 1'b0;
            if (rx_start) begin
                state_q   <= S_PID;
                crc_q     <= CRC_INIT;
                cnt_q     <= '0;
                ovf_q     <= 1'b0;
                pkt_out_q <= '0;
                pkt_len_q <= '0;
                crc_ok_q  <= 1'b0;
                crc_err_q <= 1'b0;
                len_err_q <= 1'b0;
                busy_q    <= 1'b1;
            end else begin
                case (state_q)
                    S_PID, S_CHECK: begin
                        cnt_q     <= cnt_d;
                        ovf_q     <= ovf_d;
                        crc_q     <= crc_d;
                        pkt_out_q <= pkt_out_d;
                        if (pkt_end) begin
                            state_q     <= S_DONE;
                            busy_q      <= 1'b0;
                            pkt_valid_q <= 1'b1;
                            pkt_out_q   <= final_out;
                            pkt_len_q   <= final_len;
                            crc_ok_q    <= good_d;
                            crc_err_q   <= !good_d;
                            len_err_q   <= (cnt_d < MIN_BITS) || ovf_d;
                        end else if (state_q == S_PID && accept && cnt_q == 32'd7) begin
                            state_q <= S_CHECK;
                        end
                    end
                    S_DONE:  state_q <= S_IDLE;
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign pkt_out   = pkt_out_q;
    assign pkt_len   = pkt_len_q;
    assign pkt_valid = pkt_valid_q;
    assign crc_ok    = crc_ok_q;
    assign crc_err   = crc_err_q;
    assign len_err   = len_err_q;
    assign busy      = busy_q;

endmodule
